// File: rtl/cpu_pkg.sv
// Shared widths and the writeback record type for the register-file writeback path.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = $clog2(NUM_REGS);
  localparam int DATA_W   = 16;

  // One pending register-file write: destination register and its data.
  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_rec_t;

  // Read-port bypass: r0 always reads zero. Otherwise the write being
  // presented to the register file this cycle beats the stale array value.
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [REG_AW-1:0] addr,
    input logic              wen,
    input logic [REG_AW-1:0] wdest,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] rf
  );
    if (addr == '0)
      return '0;
    else if (wen && (wdest == addr))
      return wdata;
    else
      return rf;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle of ALU, load, register-file write and read-forwarding signals of the writeback stage.
// Latency: n/a (wiring only).
// Backpressure: ld_valid/ld_ready handshake on loads; the ALU path has none (wb_stall is advisory).
// master: issue/decode/regfile side; slave: reg_writeback.
interface reg_writeback_if;
  import cpu_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_dest;
  logic [DATA_W-1:0] ld_data;

  logic              writ_en;
  logic [REG_AW-1:0] writ_dest;
  logic [DATA_W-1:0] writ_data;

  logic [REG_AW-1:0] rea_addr_1;
  logic [REG_AW-1:0] rea_addr_2;
  logic [DATA_W-1:0] rf_data_1;
  logic [DATA_W-1:0] rf_data_2;
  logic [DATA_W-1:0] fwd_data_1;
  logic [DATA_W-1:0] fwd_data_2;
  logic              pend_1;
  logic              pend_2;

  logic              wb_stall;
  logic              ovf_err;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output ld_valid, ld_dest, ld_data,
    input  ld_ready,
    input  writ_en, writ_dest, writ_data,
    output rea_addr_1, rea_addr_2, rf_data_1, rf_data_2,
    input  fwd_data_1, fwd_data_2, pend_1, pend_2,
    input  wb_stall, ovf_err
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  ld_valid, ld_dest, ld_data,
    output ld_ready,
    output writ_en, writ_dest, writ_data,
    input  rea_addr_1, rea_addr_2, rf_data_1, rf_data_2,
    output fwd_data_1, fwd_data_2, pend_1, pend_2,
    output wb_stall, ovf_err
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous DEPTH-entry FIFO of writeback records with per-entry valid/dest taps.
// Latency: a push is visible at head/count/ent_vld the cycle after the edge that takes it.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
// Ports: clk, rst (sync, active-high), push/push_rec, pop, full, empty, count, head, ent_vld, ent_dest.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_rec_t                 push_rec,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output wb_rec_t                 head,
  output logic [DEPTH-1:0]        ent_vld,
  output logic [REG_AW-1:0]       ent_dest [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  wb_rec_t          mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic [DEPTH-1:0] vld;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign ent_vld = vld;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_dest[i] = mem[i].dest;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two. The valid bit for
  // a slot can only be set and cleared in the same cycle when the FIFO is
  // empty or full, and then one of the two operations is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        vld[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        vld[rd_ptr] <= 1'b0;
      end
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset: only slots flagged valid are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_rec;
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU results and FIFO-buffered loads onto the registered regfile write port.
// Latency: ALU 1 cycle to writ_*; load into idle empty FIFO 2 cycles; forwarding is combinational.
// Backpressure: ld_ready = !full; wb_stall tells issue to hold the ALU, ovf_err flags if it does not.
// Ports: clk, rst (sync, active-high), bus (reg_writeback_if.slave) carrying all datapath signals.
module reg_writeback
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_writeback_if.slave        bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  wb_rec_t           head;
  logic [DEPTH-1:0]  ent_vld;
  logic [REG_AW-1:0] ent_dest [DEPTH];

  logic              alu_win;
  logic              ld_push;
  logic              fifo_pop;

  logic              writ_en_q;
  logic [REG_AW-1:0] writ_dest_q;
  logic [DATA_W-1:0] writ_data_q;
  logic              wb_stall_q;
  logic              ovf_err_q;
  logic              pend_1;
  logic              pend_2;

  // r0 is architecturally constant: ALU writes to it lose nothing by being
  // ignored, and loads to it complete the handshake but are never queued.
  assign alu_win      = bus.alu_valid && (bus.alu_dest != '0);
  assign fifo_pop     = !alu_win && !empty;
  assign bus.ld_ready = !full && !rst;
  assign ld_push      = bus.ld_valid && bus.ld_ready && (bus.ld_dest != '0);
  assign count_nxt    = count + CW'(ld_push) - CW'(fifo_pop);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ld_push),
    .push_rec ('{dest: bus.ld_dest, data: bus.ld_data}),
    .pop      (fifo_pop),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head),
    .ent_vld  (ent_vld),
    .ent_dest (ent_dest)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      writ_en_q   <= 1'b0;
      writ_dest_q <= '0;
      writ_data_q <= '0;
      wb_stall_q  <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      if (alu_win) begin
        writ_en_q   <= 1'b1;
        writ_dest_q <= bus.alu_dest;
        writ_data_q <= bus.alu_data;
      end else if (fifo_pop) begin
        writ_en_q   <= 1'b1;
        writ_dest_q <= head.dest;
        writ_data_q <= head.data;
      end else begin
        writ_en_q   <= 1'b0;
      end
      // Tracks the post-edge occupancy, so it is high exactly while full.
      wb_stall_q <= (count_nxt == CW'(DEPTH));
      if (bus.alu_valid && wb_stall_q) ovf_err_q <= 1'b1;
    end
  end

  // Only queued entries count; a load being pushed this cycle is not yet visible.
  always_comb begin
    pend_1 = 1'b0;
    pend_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_dest[i] == bus.rea_addr_1)) pend_1 = 1'b1;
      if (ent_vld[i] && (ent_dest[i] == bus.rea_addr_2)) pend_2 = 1'b1;
    end
    if (bus.rea_addr_1 == '0) pend_1 = 1'b0;
    if (bus.rea_addr_2 == '0) pend_2 = 1'b0;
  end

  assign bus.writ_en    = writ_en_q;
  assign bus.writ_dest  = writ_dest_q;
  assign bus.writ_data  = writ_data_q;
  assign bus.wb_stall   = wb_stall_q;
  assign bus.ovf_err    = ovf_err_q;
  assign bus.pend_1     = pend_1;
  assign bus.pend_2     = pend_2;
  assign bus.fwd_data_1 = fwd_pick(bus.rea_addr_1, writ_en_q, writ_dest_q, writ_data_q, bus.rf_data_1);
  assign bus.fwd_data_2 = fwd_pick(bus.rea_addr_2, writ_en_q, writ_dest_q, writ_data_q, bus.rf_data_2);

endmodule
